// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to 4-digit BCD converter with leading-zero blanking
module bin2bcd_seq #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    input  logic             blank_lz,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       dig3,
    output logic [3:0]       dig2,
    output logic [3:0]       dig1,
    output logic [3:0]       dig0
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_opnd;
    logic [15:0]      r_bcd;
    logic [CW-1:0]    r_cnt;
    logic             r_blank, r_ovf_pend, r_done, r_ovf;
    logic [3:0]       r_dig3, r_dig2, r_dig1, r_dig0;
    logic [15:0]      w_adj, w_bcd;
    logic             w_accept, w_last, w_b3, w_b2, w_b1;

    assign w_accept = r_state == IDLE && start;
    assign w_last   = r_state == SHIFT && r_cnt == CW'(WIDTH - 1);
    assign w_bcd    = (w_adj << 1) | 16'(r_opnd[WIDTH-1]);
    assign w_b3     = r_blank && w_bcd[15:12] == 4'd0;
    assign w_b2     = w_b3 && w_bcd[11:8] == 4'd0;
    assign w_b1     = w_b2 && w_bcd[7:4] == 4'd0;

    assign busy = r_state == SHIFT;
    assign done = r_done;
    assign ovf  = r_ovf;
    assign dig3 = r_dig3;
    assign dig2 = r_dig2;
    assign dig1 = r_dig1;
    assign dig0 = r_dig0;

    // Add-3 correction of every scratch nibble that would reach 10 or more after the shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++)
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end

    // Next state: leave IDLE on an accepted start, return once the last bit is shifted in
    always_comb begin
        w_next = r_state;
        if (w_accept) w_next = SHIFT;
        else if (w_last) w_next = IDLE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Datapath: capture on accept, one iteration per SHIFT edge, publish digits on the final edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_opnd     <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_blank    <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_dig3     <= 4'hF;
            r_dig2     <= 4'hF;
            r_dig1     <= 4'hF;
            r_dig0     <= 4'hF;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_opnd     <= bin;
                r_blank    <= blank_lz;
                r_ovf_pend <= 32'(bin) > 32'd9999;
                r_bcd      <= '0;
                r_cnt      <= '0;
            end else if (r_state == SHIFT) begin
                r_opnd <= r_opnd << 1;
                r_bcd  <= w_bcd;
                r_cnt  <= r_cnt + CW'(1);
            end
            if (w_last) begin
                r_ovf  <= r_ovf_pend;
                r_dig3 <= (r_ovf_pend || w_b3) ? 4'hF : w_bcd[15:12];
                r_dig2 <= (r_ovf_pend || w_b2) ? 4'hF : w_bcd[11:8];
                r_dig1 <= (r_ovf_pend || w_b1) ? 4'hF : w_bcd[7:4];
                r_dig0 <= r_ovf_pend ? 4'hF : w_bcd[3:0];
            end
        end
    end
endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 14, giving the binary input width; the legal range is 4..14.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The module SHALL have port start, input, 1 bit: conversion request, sampled on clk rising edges.
REQ-005 The module SHALL have port bin, input, WIDTH bits: unsigned value, captured when start is accepted.
REQ-006 The module SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable, captured when start is accepted.
REQ-007 The module SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse when the digit outputs update.
REQ-009 The module SHALL have port ovf, output, 1 bit: the last accepted bin exceeded 9999.
REQ-010 The module SHALL have ports dig3, dig2, dig1, dig0, output, 4 bits each: BCD digits (thousands..units) or 4'hF for blank; each feeds one 7-segment decoder instance directly.

Function
REQ-011 The FSM SHALL have two states: IDLE and SHIFT.
REQ-012 In IDLE with start=1 at an edge, the FSM SHALL do all of the following on that edge: capture bin and blank_lz, clear the BCD scratch register, set the iteration count to 0, and enter SHIFT; busy SHALL be 1 from the following cycle.
REQ-013 On each SHIFT edge, the block SHALL perform one double-dabble iteration: add 3 to every scratch BCD nibble >= 5, then shift {scratch, operand} left by 1, and increment the count.
REQ-014 On the edge completing iteration WIDTH, the block SHALL load the digit outputs, return the FSM to IDLE and drive busy=0 and done=1 for exactly one cycle; the latency from the start-accepting edge to the done-high cycle is therefore WIDTH edges.
REQ-015 start SHALL be ignored while in SHIFT, with no queuing and no effect on the running conversion.
REQ-016 start=1 during the done cycle (IDLE) SHALL be accepted, allowing back-to-back conversions every WIDTH+1 cycles.
REQ-017 Overflow: if the captured bin exceeds 9999, the block SHALL still take the full WIDTH cycles, and at done it SHALL drive ovf=1 and all four digits to 4'hF.
REQ-018 Without overflow, ovf SHALL be 0 at done; ovf SHALL update only at done.
REQ-019 With blank_lz captured as 1, every digit above the most significant nonzero digit SHALL output 4'hF; dig0 SHALL never be blanked, so a value of 0 shows as F,F,F,0.
REQ-020 With blank_lz captured as 0, the block SHALL output all four digits as BCD, including leading zeros.
REQ-021 dig3..dig0 and ovf SHALL hold their values between done pulses, and a new conversion SHALL NOT alter them until its own done.
REQ-022 Digit values SHALL be only 0..9 or 4'hF, never 4'hA..4'hE.

Reset
REQ-023 When rst_n=0 at an edge, the block SHALL enter IDLE with busy=0, done=0, ovf=0, and dig3..dig0=4'hF (blank display).
REQ-024 Reset asserted mid-conversion SHALL abort the conversion: no done pulse, outputs forced to their reset values.
REQ-025 start SHALL be ignored on any edge where rst_n=0.

Verification
REQ-026 Test 1 (basic conversion): WIDTH=14, bin=1234, blank_lz=0, start pulsed -> done exactly 14 edges after acceptance; digits 1,2,3,4; ovf=0; busy high for 14 cycles.
REQ-027 Test 2 (blanking): bin=0 with blank_lz=1 -> F,F,F,0; bin=0 with blank_lz=0 -> 0,0,0,0; bin=305 with blank_lz=1 -> F,3,0,5.
REQ-028 Test 3 (range boundary): bin=9999 -> 9,9,9,9 with ovf=0; bin=10000 -> F,F,F,F with ovf=1; bin=16383 -> F,F,F,F with ovf=1.
REQ-029 Test 4 (start while busy): start held high for 20 cycles with bin changing each cycle -> only the first value is converted, digits stay stable until its done, then the value present during the done cycle is accepted.
REQ-030 Test 5 (reset mid-conversion): rst_n=0 at iteration 7 of bin=4321 -> no done pulse; outputs F,F,F,F, ovf=0, busy=0; a following start with bin=42 yields 0,0,4,2.
REQ-031 Test 6 (randomized check): 1000 random values 0..16383 with random blank_lz, compared against a reference model -> zero mismatches, done spacing never below WIDTH+1.
